riscv_data_memory: RTL and testbench
====================================

// Module: riscv_data_memory
// PURPOSE
//  - Doubleword data memory for the 64-bit RISC-V pipeline, instantiated in the MEM stage.
//  - Load path: combinational read. Store path: synchronous write on the rising clock edge.
//  - Byte-addressed interface; every access is one aligned 64-bit doubleword.
// PARAMETERS
//  - DEPTH      1024  number of 64-bit words (8 KiB); power of two, >= 2
//  - BASE_ADDR  0     byte address of word 0; aligned to DEPTH*8
// PORTS
//  - clk         in   1   clock; all state updates on the rising edge
//  - reset       in   1   asynchronous, active-high reset
//  - mem_read    in   1   load enable
//  - mem_write   in   1   store enable
//  - address     in   64  byte address, taken from the ALU result
//  - write_data  in   64  store data (rs2)
//  - read_data   out  64  load data; combinational
//  - access_err  out  1   present only when DMEM_ERR_EN is defined; combinational
// BEHAVIOUR
//  - Reset: one clock, asynchronous active-high reset (fixed).
//    - reset=1 asynchronously clears every word to 0.
//    - Stores are blocked while reset=1.
//    - read_data therefore reads 0 during reset.
//  - Index: off = address - BASE_ADDR; idx = off[$clog2(DEPTH)+2:3]; in_range = (off < DEPTH*8).
//  - Alignment: address[2:0] is ignored. A misaligned access hits the containing doubleword.
//  - Read: read_data = (mem_read && in_range) ? mem[idx] : 64'd0. Zero latency, no handshake.
//  - Write: at posedge clk, if mem_write && in_range && !reset, then mem[idx] <= write_data.
//  - Out-of-range write: ignored; no word changes.
//  - Read and write to the same idx in one cycle:
//    - read_data shows the old value before the edge.
//    - read_data shows the new value after the edge.
//  - mem_read and mem_write both high: the write is performed and the read is still served.
//  - Reset deasserted mid-cycle: the next rising edge may write normally.
//  - Address arithmetic is unsigned 64-bit. If address < BASE_ADDR, off wraps to a huge value, so the access is out of range.
// CONFIGURATION
//  - Macro DMEM_ERR_EN.
//  - Defined:
//    - access_err = (mem_read|mem_write) && (!in_range || address[2:0]!=0).
//    - access_err is 0 while reset=1.
//    - Data behaviour is unchanged.
//  - Undefined: the access_err port and its logic are absent.
// STRUCTURE
//  - Package dmem_pkg:
//    - localparams DWORD_BYTES=8, OFFSET_BITS=3, DATA_W=64.
//    - typedef dword_t (logic [63:0]).
//  - One sub-module, dmem_addr_decode: address -> idx, in_range, misaligned.
//  - Storage array plus read mux live in the top module.
// TESTING
//  - Reset: pulse reset, read addresses 0x0, 0x8 and 0x1FF8 -> read_data = 0.
//  - Store/load:
//    - Write 0xDEADBEEF_CAFEF00D to 0x10.
//    - Read 0x10 next cycle -> same value.
//    - Read 0x18 -> 0.
//  - mem_read=0 with valid data stored at 0x10 -> read_data = 0.
//  - Out of range:
//    - Write 0x55 to 0x2000 (DEPTH=1024); read 0x2000 -> 0.
//    - Word 0 stays unchanged.
//    - With DMEM_ERR_EN: access_err = 1.
//  - Misaligned: write 0x1234 to 0x23, read 0x20 -> 0x1234; access_err = 1 (DMEM_ERR_EN).
//  - Async reset:
//    - Store 0x77 at 0x8.
//    - Assert reset between edges -> read 0x8 returns 0 immediately.
//    - A write attempted while reset=1 is dropped.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the RISC-V doubleword data memory.
// Contents: doubleword geometry localparams and the dword_t data type.
package dmem_pkg;

   localparam int DWORD_BYTES = 8;   // bytes per doubleword
   localparam int OFFSET_BITS = 3;   // byte-offset bits inside a doubleword
   localparam int DATA_W      = 64;  // data path width
   localparam int ADDR_W      = 64;  // byte address width

   typedef logic [DATA_W-1:0] dword_t;

endpackage : dmem_pkg

// File: rtl/dmem_addr_decode.sv
// Address decoder for the data memory.
// Turns a byte address into a word index, an in-range flag and a misalignment flag.
// Ports:
//   address    in   ADDR_W          byte address from the ALU
//   idx        out  $clog2(DEPTH)   doubleword index into the storage array
//   in_range   out  1               address falls inside [BASE_ADDR, BASE_ADDR + DEPTH*8)
//   misaligned out  1               address[2:0] is non-zero
module dmem_addr_decode
   import dmem_pkg::*;
#(
   parameter int                DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 64'd0
) (
   input  logic [ADDR_W-1:0]        address,
   output logic [$clog2(DEPTH)-1:0] idx,
   output logic                     in_range,
   output logic                     misaligned
);

   localparam int                IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] SPAN  = 64'(DEPTH) * 64'(DWORD_BYTES);

   logic [ADDR_W-1:0] off_s;

   // Unsigned wrap: an address below BASE_ADDR becomes a huge offset and
   // therefore fails the range compare. BASE_ADDR is doubleword aligned, so
   // the low offset bits equal the low address bits.
   assign off_s = address - BASE_ADDR;

   // Decode index, range and alignment from the base-relative offset
   always_comb begin
      idx        = off_s[IDX_W+OFFSET_BITS-1:OFFSET_BITS];
      in_range   = (off_s < SPAN);
      misaligned = (off_s[OFFSET_BITS-1:0] != {OFFSET_BITS{1'b0}});
   end

endmodule : dmem_addr_decode

// File: rtl/riscv_data_memory.sv
// Doubleword data memory for the 64-bit RISC-V pipeline (MEM stage).
// Combinational load path, synchronous store on the rising clock edge,
// asynchronous active-high reset that clears every word.
// Optional feature: define DMEM_ERR_EN to add the access_err output.
// Ports:
//   clk         in   1    clock
//   reset       in   1    asynchronous active-high reset, clears storage
//   mem_read    in   1    load enable
//   mem_write   in   1    store enable
//   address     in   64   byte address (low 3 bits ignored)
//   write_data  in   64   store data
//   read_data   out  64   load data, combinational
//   access_err  out  1    (DMEM_ERR_EN only) out-of-range or misaligned access
module riscv_data_memory
   import dmem_pkg::*;
#(
   parameter int                DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 64'd0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] address,
   input  dword_t            write_data,
   output dword_t            read_data
`ifdef DMEM_ERR_EN
   ,
   output logic              access_err
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   dword_t           mem_r [DEPTH];
   logic [IDX_W-1:0] idx_s;
   logic             in_range_s;
   logic             misaligned_s;

   dmem_addr_decode #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE_ADDR)
   ) u_decode (
      .address    (address),
      .idx        (idx_s),
      .in_range   (in_range_s),
      .misaligned (misaligned_s)
   );

   // Storage: async clear on reset, otherwise in-range stores update one word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 64'd0;
         end
      end else if (mem_write && in_range_s) begin
         mem_r[idx_s] <= write_data;
      end else begin
         mem_r[idx_s] <= mem_r[idx_s];
      end
   end

   // Load mux: zero unless an enabled, in-range read
   always_comb begin
      if (mem_read && in_range_s) begin
         read_data = mem_r[idx_s];
      end else begin
         read_data = 64'd0;
      end
   end

`ifdef DMEM_ERR_EN
   // Flag any enabled access that is out of range or not doubleword aligned
   always_comb begin
      if (reset) begin
         access_err = 1'b0;
      end else begin
         access_err = (mem_read | mem_write) && (!in_range_s || misaligned_s);
      end
   end
`else
   // Alignment is irrelevant when no error output exists
   logic unused_misaligned_s;
   assign unused_misaligned_s = misaligned_s;
`endif

endmodule : riscv_data_memory

// File: tb/tb_riscv_data_memory.sv
// Directed self-checking bench for riscv_data_memory (DEPTH=1024, BASE_ADDR=0).
module tb_riscv_data_memory;

   logic        clk;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] address;
   logic [63:0] write_data;
   logic [63:0] read_data;
`ifdef DMEM_ERR_EN
   logic        access_err;
`endif

   int checks_cnt;
   int errors_cnt;

   riscv_data_memory #(
      .DEPTH     (1024),
      .BASE_ADDR (64'd0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data)
`ifdef DMEM_ERR_EN
      ,
      .access_err (access_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: actual 0x%016h required 0x%016h", tag, obs, exp);
      end
   endtask

   // Store one word: drive after an edge, commit on the next rising edge
   task automatic write_word(input logic [63:0] addr, input logic [63:0] data);
      mem_write  = 1'b1;
      mem_read   = 1'b0;
      address    = addr;
      write_data = data;
      @(posedge clk);
      #1;
      mem_write  = 1'b0;
   endtask

   // Combinational load check, no clock edge consumed
   task automatic read_check(input string tag, input logic [63:0] addr, input logic [63:0] exp);
      mem_read = 1'b1;
      address  = addr;
      #1;
      check(tag, read_data, exp);
   endtask

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      reset      = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      address    = 64'd0;
      write_data = 64'd0;

`ifdef DMEM_ERR_EN
      // Error flag is suppressed during reset even for a bad access
      mem_read = 1'b1;
      address  = 64'h2000;
      #1;
      check("err_in_reset", {63'd0, access_err}, 64'd0);
      mem_read = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      read_check("rst_0x0",    64'h0,    64'd0);
      read_check("rst_0x8",    64'h8,    64'd0);
      read_check("rst_0x1ff8", 64'h1FF8, 64'd0);

      // Same-index read during write: old value before edge, new after
      @(posedge clk);
      #1;
      mem_read   = 1'b1;
      mem_write  = 1'b1;
      address    = 64'h10;
      write_data = 64'hDEADBEEF_CAFEF00D;
      #1;
      check("rw_old", read_data, 64'd0);
`ifdef DMEM_ERR_EN
      check("err_aligned", {63'd0, access_err}, 64'd0);
`endif
      @(posedge clk);
      #1;
      check("rw_new", read_data, 64'hDEADBEEF_CAFEF00D);
      mem_write = 1'b0;

      read_check("ld_0x10", 64'h10, 64'hDEADBEEF_CAFEF00D);
      read_check("ld_0x18", 64'h18, 64'd0);
      mem_read = 1'b0;
      address  = 64'h10;
      #1;
      check("rd_disabled", read_data, 64'd0);

      // Boundary words and out-of-range store
      write_word(64'h0,    64'h0000_0000_0000_A5A5);
      write_word(64'h1FF8, 64'h1111_2222_3333_4444);
      read_check("ld_last", 64'h1FF8, 64'h1111_2222_3333_4444);
      mem_write  = 1'b1;
      address    = 64'h2000;
      write_data = 64'h55;
      #1;
`ifdef DMEM_ERR_EN
      check("err_oor", {63'd0, access_err}, 64'd1);
`endif
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      read_check("ld_oor",   64'h2000, 64'd0);
      read_check("word0_ok", 64'h0,    64'h0000_0000_0000_A5A5);
      read_check("last_ok",  64'h1FF8, 64'h1111_2222_3333_4444);

      // Misaligned store hits the containing doubleword
      mem_write  = 1'b1;
      mem_read   = 1'b0;
      address    = 64'h23;
      write_data = 64'h1234;
      #1;
`ifdef DMEM_ERR_EN
      check("err_misalign", {63'd0, access_err}, 64'd1);
`endif
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      read_check("ld_misal_0x20", 64'h20, 64'h1234);
      read_check("ld_misal_0x27", 64'h27, 64'h1234);

      // Async reset between edges clears storage immediately
      write_word(64'h8, 64'h77);
      read_check("ld_0x8", 64'h8, 64'h77);
      #2;
      reset = 1'b1;
      #1;
      check("async_clr_0x8", read_data, 64'd0);
      read_check("async_clr_0x10", 64'h10, 64'd0);

      // Store attempted while reset is held is dropped
      mem_write  = 1'b1;
      address    = 64'h8;
      write_data = 64'h88;
      @(posedge clk);
      #3;
      mem_write = 1'b0;
      reset     = 1'b0;
      read_check("drop_in_rst", 64'h8, 64'd0);

      // Reset released mid-cycle: next edge writes normally
      write_word(64'h8, 64'h99);
      read_check("wr_after_rst", 64'h8, 64'h99);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule : tb_riscv_data_memory
